// File: rtl/pll_reset_seq.sv
// -----------------------------------------------------------------------------
// pll_reset_seq
//   PLL control sequencer in the clkin domain. Holds the PLL in reset, waits
//   for lock, requires a stable lock window, then releases the system reset
//   and generates the CPU clock-enable. Loss of lock or a lock timeout sends
//   the PLL back through reset.
//
//   Optional feature macro: PLL_LOCK_FAULT_EN
//     defined   -> more than MAX_RETRY consecutive retries enter a sticky FAULT
//                  state (exit only via rst)
//     undefined -> unlimited retries, fault tied low
//
// Ports
//   clkin      in   clock, rising edge
//   rst        in   synchronous active-high reset
//   locked_in  in   asynchronous PLL lock flag (2-FF synchronised internally)
//   pll_rst    out  PLL reset, registered
//   sys_rst    out  system reset (active-high), registered
//   cpu_ce     out  one-cycle CPU clock-enable pulse every CE_DIV cycles in RUN
//   state_o    out  0 PLLRST, 1 WAIT, 2 SETTLE, 3 RUN (FAULT reads as 0)
//   retry_o    out  reset attempts since last RUN, saturating at 15
//   fault      out  fatal lock failure
// -----------------------------------------------------------------------------
module pll_reset_seq #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int CE_DIV         = 16,
    parameter int MAX_RETRY      = 7
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       locked_in,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       cpu_ce,
    output logic [1:0] state_o,
    output logic [3:0] retry_o,
    output logic       fault
);

    localparam int MAXA = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAXC = (MAXA > SETTLE_CYCLES) ? MAXA : SETTLE_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int DW   = $clog2(CE_DIV);

    localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] CE_LAST  = DW'(CE_DIV - 1);

    typedef enum logic [2:0] {
        S_PLLRST = 3'd0,
        S_WAIT   = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3
`ifdef PLL_LOCK_FAULT_EN
        , S_FAULT = 3'd4
`endif
    } state_t;

    state_t          state, nstate;
    logic [CW-1:0]   cnt, ncnt;
    logic [DW-1:0]   div, ndiv;
    logic [3:0]      nretry;
    logic            retry_req;
    logic            lk_m, lk_s;

    // Lock synchroniser
    always_ff @(posedge clkin) begin
        if (rst) begin
            lk_m <= 1'b0;
            lk_s <= 1'b0;
        end else begin
            lk_m <= locked_in;
            lk_s <= lk_m;
        end
    end

    always_comb begin
        nstate    = state;
        ncnt      = cnt;
        ndiv      = '0;
        nretry    = retry_o;
        retry_req = 1'b0;
        case (state)
            S_PLLRST: begin
                if (cnt == RST_LAST) begin
                    nstate = S_WAIT;
                    ncnt   = '0;
                end else begin
                    ncnt = cnt + CW'(1);
                end
            end
            S_WAIT: begin
                if (lk_s) begin
                    nstate = S_SETTLE;
                    ncnt   = '0;
                end else if (cnt == TO_LAST) begin
                    retry_req = 1'b1;
                end else begin
                    ncnt = cnt + CW'(1);
                end
            end
            S_SETTLE: begin
                if (!lk_s) begin
                    retry_req = 1'b1;
                end else if (cnt == SET_LAST) begin
                    nstate = S_RUN;
                    ncnt   = '0;
                    nretry = 4'd0;
                end else begin
                    ncnt = cnt + CW'(1);
                end
            end
            S_RUN: begin
                if (!lk_s) begin
                    retry_req = 1'b1;
                end else begin
                    ndiv = (div == CE_LAST) ? '0 : div + DW'(1);
                end
            end
            default: begin
`ifdef PLL_LOCK_FAULT_EN
                // FAULT is sticky; only rst leaves it
                nstate = state;
`else
                nstate = S_PLLRST;
                ncnt   = '0;
`endif
            end
        endcase

        // Common retry path: back to PLL reset with a saturating attempt count
        if (retry_req) begin
            ncnt = '0;
`ifdef PLL_LOCK_FAULT_EN
            if (retry_o >= 4'(MAX_RETRY)) begin
                nstate = S_FAULT;
            end else begin
                nstate = S_PLLRST;
                nretry = retry_o + 4'd1;
            end
`else
            nstate = S_PLLRST;
            nretry = (retry_o == 4'hF) ? retry_o : retry_o + 4'd1;
`endif
        end
    end

    // State plus outputs registered from the next state
    always_ff @(posedge clkin) begin
        if (rst) begin
            state   <= S_PLLRST;
            cnt     <= '0;
            div     <= '0;
            retry_o <= 4'd0;
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
            cpu_ce  <= 1'b0;
            state_o <= 2'd0;
        end else begin
            state   <= nstate;
            cnt     <= ncnt;
            div     <= ndiv;
            retry_o <= nretry;
            pll_rst <= (nstate != S_WAIT) && (nstate != S_SETTLE) && (nstate != S_RUN);
            sys_rst <= (nstate != S_RUN);
            cpu_ce  <= (nstate == S_RUN) && (ndiv == CE_LAST);
            case (nstate)
                S_WAIT:   state_o <= 2'd1;
                S_SETTLE: state_o <= 2'd2;
                S_RUN:    state_o <= 2'd3;
                default:  state_o <= 2'd0;
            endcase
        end
    end

`ifdef PLL_LOCK_FAULT_EN
    always_ff @(posedge clkin) begin
        if (rst) fault <= 1'b0;
        else     fault <= (nstate == S_FAULT);
    end
`else
    assign fault = 1'b0;
`endif

endmodule
